uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter that serializes bytes onto a single output line, the transmit counterpart to the byte-input datapath in the chip-camp top level. Up to FIFO_DEPTH bytes are accepted over a valid/ready handshake. A frame FSM emits each byte as start bit, 8 data bits LSB-first, optional parity and stop bit, with a programmable number of clocks per bit. The block is intended to drive a uio pin with its output enable tied high.

## Interface
- CLK_DIV, 16: clock cycles per serial bit; legal range 2..256.
- FIFO_DEPTH, 4: byte entries in the input FIFO; power of two, 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  FIFO can accept a byte; a transfer occurs on the edge where valid_in && ready_out.
- tx  output  1  serial line, idle high.
- busy  output  1  FSM is not in IDLE.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently stored.

## Operation
- All outputs are registered, except ready_out = (fifo_level != FIFO_DEPTH).
- Reset values: tx=1, busy=0, fifo_level=0, ready_out=1, FSM=IDLE, all counters 0.
- FIFO behaviour:
  - Circular buffer with separate read and write pointers that wrap at FIFO_DEPTH.
  - A push and a pop on the same edge leave fifo_level unchanged.
  - When the FIFO is full, ready_out is low and no push occurs; valid_in is ignored.
- FSM states:
  - IDLE → START when fifo_level != 0. The head byte is popped into the shift register on that edge.
  - START: tx=0 for CLK_DIV cycles → DATA.
  - DATA: tx=shift[0]. Shift right every CLK_DIV cycles. After 8 bits → PARITY if enabled, else STOP.
  - PARITY: tx = even parity (XOR of the 8 data bits) for CLK_DIV cycles → STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then → START with a pop if the FIFO is non-empty, else → IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and resets to 0 on every state change.
  - The bit counter is 3 bits; DATA exits when the bit counter is 7 and the baud counter is CLK_DIV-1.
- Back-to-back bytes: no idle cycles between one frame's stop bit and the next start bit.
- Reset mid-frame: the frame is aborted, tx returns high asynchronously, and FIFO contents are discarded.

## Timing
- Latency: a byte accepted at edge E into an empty FIFO with FSM IDLE pops at edge E+1. tx falls at E+1, so the start bit is visible after E+1.
- Each bit lasts exactly CLK_DIV cycles.
- Frame length: 10·CLK_DIV cycles, or 11·CLK_DIV with parity.
- busy rises on the edge that enters START. It falls on the edge that returns the FSM to IDLE, which is the edge ending the stop bit.
- fifo_level updates on the edge after the push/pop. ready_out follows combinationally in the same cycle.
- Sustained throughput is one byte per frame length. With continuous valid_in, ready_out deasserts once FIFO_DEPTH bytes are queued beyond the one being shifted.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in and the frame is 11 bits with an even parity bit after data bit 7.
- UART_TX_PARITY_EN undefined: the PARITY state and parity logic are absent and the frame is 10 bits (8N1).

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4 unless stated.
- Reset check: assert rst for 3 cycles → tx=1, busy=0, ready_out=1, fifo_level=0.
- Single byte: push 0xA5 in IDLE → tx reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles starting at E+1. busy is high for exactly 40 cycles.
- Parity (UART_TX_PARITY_EN defined):
  - Push 0xA5 → parity bit 0 inserted before stop; frame is 44 cycles.
  - Push 0x01 → parity bit 1.
- Back-pressure: hold valid_in=1 with bytes 0x00..0x09 → ready_out drops after 5 accepts. All 10 bytes appear in order with no idle gaps; total 400 cycles after the first start bit.
- Simultaneous push/pop: with fifo_level=2, push on the same edge as a STOP→START pop → fifo_level stays 2 and byte order is preserved.
- Reset mid-frame: assert rst during data bit 3 of 0x55 with 2 bytes queued → tx=1 immediately, fifo_level=0. After release, the line stays idle and busy=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop frame FSM.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_q;
    logic            push, pop, baud_end, fifo_nonempty;
    logic            tx_d, busy_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign ready_out     = (level_q != LW'(FIFO_DEPTH));
    assign fifo_level    = level_q;
    assign push          = valid_in && ready_out;
    assign baud_end      = (baud_q == BW'(CLK_DIV - 1));
    assign fifo_nonempty = (level_q != '0);

    // Next-state, counters, shift register and next line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (fifo_nonempty) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                end
            end
            START: begin
                if (baud_end) state_d = DATA;
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (fifo_nonempty) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_PARITY_EN
        parity_d = pop ? ^mem[rd_ptr] : parity_q;
`endif
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM, counters and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            busy     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage; contents are dropped by resetting the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=4.
// A line monitor decodes frames and compares them to queued bytes.
module tb_uart_tx_fifo;

    localparam int CD = 4;
    localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    uart_tx_fifo #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         frames = 0;
    int         cyc = 0;
    logic       inf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line monitor: frame decode and cycle-exact bit comparison.
    initial begin : mon
        int         fc;
        int         glitches;
        int         bitn;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        fc = 0; glitches = 0; exp_b = 8'h00; got_b = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                inf = 1'b0;
            end else begin
                if (!inf && tx == 1'b0) begin
                    inf = 1'b1;
                    fc = 0;
                    glitches = 0;
                    got_b = 8'h00;
                    start_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                        exp_b = 8'h00;
                    end else begin
                        exp_b = exp_q.pop_front();
                    end
                end
                if (inf) begin
                    bitn = fc / CD;
                    if (tx !== frame_bit(exp_b, bitn)) glitches++;
                    if ((fc % CD) == CD / 2 && bitn >= 1 && bitn <= 8)
                        got_b[bitn-1] = tx;
                    fc++;
                    if (fc == FL) begin
                        check("frame_byte", got_b, exp_b);
                        check("frame_bits", glitches, 0);
                        frames++;
                        inf = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int waited);
        int n;
        n = 0;
        @(negedge clk);
        data_in  = b;
        valid_in = 1'b1;
        while (!ready_out && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("push_timeout", 0, 1);
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        valid_in = 1'b0;
        waited = n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || fifo_level != 0 || inf) && n < 3000);
        if (n >= 3000) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != target && n < 3000);
        if (n >= 3000) check("cyc_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int w;
        int bc;
        int first_stall;
        int s;
        int lows;
        int busys;

        rst = 1'b1; valid_in = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", ready_out, 1);
        check("rst_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single byte: latency and busy duration
        push(8'hA5, w);
        check("lat_pre_tx", tx, 1);
        check("lat_pre_busy", busy, 0);
        check("lat_pre_level", fifo_level, 1);
        @(posedge clk);
        #1;
        check("lat_tx_fall", tx, 0);
        check("lat_busy", busy, 1);
        check("lat_level", fifo_level, 0);
        bc = 1;
        repeat (FL + 10) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
        end
        check("busy_len", bc, FL);
        check("single_frames", frames, 1);

        // Parity-distinguishing patterns
        push(8'h01, w);
        wait_idle();
        push(8'hFF, w);
        wait_idle();
        push(8'h80, w);
        wait_idle();
        check("pattern_frames", frames, 4);

        // Back-pressure with continuous stream
        start_cyc.delete();
        first_stall = -1;
        for (int i = 0; i < 10; i++) begin
            push(8'(i), w);
            if (w > 0 && first_stall < 0) first_stall = i;
        end
        check("accepts_before_stall", first_stall, 5);
        wait_idle();
        check("bp_frames", frames, 14);
        for (int k = 1; k < 10; k++)
            check("bp_gap", start_cyc[k] - start_cyc[k-1], FL);

        // Push on the STOP->START pop edge
        start_cyc.delete();
        push(8'h3C, w);
        push(8'hC3, w);
        push(8'h5A, w);
        s = start_cyc[0];
        wait_cyc(s + FL - 1);
        check("sim_level_pre", fifo_level, 2);
        data_in  = 8'h96;
        valid_in = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h96);
        #1;
        valid_in = 1'b0;
        check("sim_level_post", fifo_level, 2);
        check("sim_tx_start", tx, 0);
        wait_idle();
        check("sim_frames", frames, 18);

        // Reset during data bit 3 of 0x55
        start_cyc.delete();
        push(8'h55, w);
        push(8'h11, w);
        push(8'h22, w);
        s = start_cyc[0];
        wait_cyc(s + 17);
        check("bit3_tx", tx, 0);
        check("pre_rst_level", fifo_level, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        busys = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx) lows++;
            if (busy) busys++;
        end
        check("post_rst_tx_low", lows, 0);
        check("post_rst_busy", busys, 0);

        // Recovery after reset
        push(8'hE7, w);
        wait_idle();
        check("total_frames", frames, 19);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
